// File: rtl/m16_rx.sv
// M16 orbit serial receiver: recovers bit timing, finds phrase alignment from the
// bit-11 markers, then tracks group/frame position and emits each word with its address.
module m16_rx #(
    parameter int CONFIRM = 2,
    parameter int MISS    = 3
) (
    input  logic        iClkOrb,
    input  logic        reset,
    input  logic        iOrbit,
    output logic [11:0] oWord,
    output logic        oVal,
    output logic [10:0] oAddr,
    output logic [4:0]  oGrp,
    output logic [6:0]  oFrm,
    output logic        oPhrLock,
    output logic        oGrpLock,
    output logic        oFrmLock,
    output logic        oErr
);
    typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

    localparam logic [31:0] PMARK  = 32'h4504_0154;
    localparam logic [7:0]  GNORM  = 8'b0111_0010;
    localparam logic [7:0]  G31    = 8'b1000_1101;
    localparam logic [3:0]  CONF_N = 4'(CONFIRM);
    localparam logic [3:0]  MISS_N = 4'(MISS);

    state_t       r_state, w_state_nx;
    logic         r_s1, r_s2, r_s3;
    logic [1:0]   r_ph;
    logic [383:0] r_hist;
    logic [3:0]   r_bitcnt, w_bitcnt_nx;
    logic [10:0]  r_widx, w_widx_nx;
    logic [3:0]   r_good, w_good_nx;
    logic [3:0]   r_miss, w_miss_nx;
    logic         r_bad, w_bad_nx;
    logic [7:0]   r_gsr, w_gsr_nx;
    logic [11:0]  w_word_nx;
    logic [10:0]  w_addr_nx;
    logic [4:0]   w_grp_nx;
    logic [6:0]   w_frm_nx;
    logic         w_val_nx, w_err_nx, w_plk_nx, w_glk_nx, w_flk_nx;

    logic [383:0] w_hist;
    logic [11:0]  w_word;
    logic [10:0]  w_k;
    logic         w_samp, w_wend, w_hunt, w_mk_bad, w_phr_bad;

    // The bit being sampled this cycle is already part of the history seen by the matchers.
    assign w_samp   = (r_ph == 2'd1);
    assign w_hist   = {r_hist[382:0], r_s2};
    assign w_word   = w_hist[11:0];
    assign w_wend   = w_samp && (r_bitcnt == 4'd11);
    assign w_k      = r_widx + 11'd1;
    assign w_mk_bad = (w_k[4:0] != 5'd16) && (w_word[11] != PMARK[w_k[4:0]]);

    always_comb begin
        w_hunt = 1'b1;
        for (int k = 0; k < 32; k++)
            if (k != 16 && w_hist[11 + 12*(31-k)] != PMARK[k]) w_hunt = 1'b0;
    end

    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_ph   <= 2'd0;
            r_hist <= '0;
        end else begin
            r_s1 <= iOrbit;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_ph <= (r_s2 != r_s3) ? 2'd0 : r_ph + 2'd1;
            if (w_samp) r_hist <= w_hist;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_bitcnt_nx = r_bitcnt;
        w_widx_nx   = r_widx;
        w_good_nx   = r_good;
        w_miss_nx   = r_miss;
        w_bad_nx    = r_bad;
        w_gsr_nx    = r_gsr;
        w_word_nx   = oWord;
        w_addr_nx   = oAddr;
        w_grp_nx    = oGrp;
        w_frm_nx    = oFrm;
        w_plk_nx    = oPhrLock;
        w_glk_nx    = oGrpLock;
        w_flk_nx    = oFrmLock;
        w_val_nx    = 1'b0;
        w_err_nx    = 1'b0;
        w_phr_bad   = r_bad | w_mk_bad;
        if (w_samp) begin
            w_bitcnt_nx = (r_bitcnt == 4'd11) ? 4'd0 : r_bitcnt + 4'd1;
            case (r_state)
                HUNT: if (w_hunt) begin
                    w_bitcnt_nx = 4'd0;
                    w_widx_nx   = {r_widx[10:5], 5'd31};
                    w_good_nx   = 4'd1;
                    w_state_nx  = CHECK;
                end
                CHECK: if (w_wend) begin
                    w_widx_nx = w_k;
                    if (w_mk_bad) begin
                        w_state_nx = HUNT;
                    end else if (w_k[4:0] == 5'd31) begin
                        w_good_nx = r_good + 4'd1;
                        if (r_good + 4'd1 >= CONF_N) begin
                            w_state_nx = LOCK;
                            w_plk_nx   = 1'b1;
                            w_miss_nx  = 4'd0;
                            w_bad_nx   = 1'b0;
                            w_gsr_nx   = 8'd0;
                        end
                    end
                end
                LOCK: if (w_wend) begin
                    w_val_nx  = 1'b1;
                    w_word_nx = w_word;
                    w_widx_nx = w_k;
                    w_err_nx  = w_mk_bad;
                    w_bad_nx  = w_phr_bad;
                    if (w_k == 11'd0) begin
                        w_grp_nx = oGrp + 5'd1;
                        w_frm_nx = oFrm + 7'd1;
                    end
                    // k=16 carries the group marker stream and, in group 0, the frame marker.
                    if (w_k[4:0] == 5'd16) begin
                        w_gsr_nx = {r_gsr[6:0], w_word[11]};
                        if (!oGrpLock) begin
                            if (w_gsr_nx == GNORM) begin
                                w_widx_nx = 11'd2032;
                            end else if (w_gsr_nx == G31) begin
                                w_widx_nx = 11'd2032;
                                w_grp_nx  = 5'd31;
                                w_glk_nx  = 1'b1;
                            end
                        end else if (w_k == 11'd2032 &&
                                     w_gsr_nx != ((oGrp == 5'd31) ? G31 : GNORM)) begin
                            w_glk_nx = 1'b0;
                            w_flk_nx = 1'b0;
                            w_err_nx = 1'b1;
                        end
                        if (oGrpLock && oGrp == 5'd0 && w_k == 11'd240) begin
                            if (!oFrmLock) begin
                                if (w_word[11]) begin
                                    w_frm_nx = 7'd0;
                                    w_flk_nx = 1'b1;
                                end
                            end else if (w_word[11] != (oFrm == 7'd0)) begin
                                w_flk_nx = 1'b0;
                                w_err_nx = 1'b1;
                            end
                        end
                    end
                    if (w_k[4:0] == 5'd31) begin
                        w_bad_nx = 1'b0;
                        if (!w_phr_bad) begin
                            w_miss_nx = 4'd0;
                        end else if (r_miss + 4'd1 >= MISS_N) begin
                            w_state_nx = HUNT;
                            w_miss_nx  = 4'd0;
                            w_plk_nx   = 1'b0;
                            w_glk_nx   = 1'b0;
                            w_flk_nx   = 1'b0;
                            w_grp_nx   = 5'd0;
                            w_frm_nx   = 7'd0;
                        end else begin
                            w_miss_nx = r_miss + 4'd1;
                        end
                    end
                    w_addr_nx = w_widx_nx;
                end
                default: w_state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            r_state  <= HUNT;
            r_bitcnt <= 4'd0;
            r_widx   <= 11'd0;
            r_good   <= 4'd0;
            r_miss   <= 4'd0;
            r_bad    <= 1'b0;
            r_gsr    <= 8'd0;
            oWord    <= 12'd0;
            oVal     <= 1'b0;
            oAddr    <= 11'd0;
            oGrp     <= 5'd0;
            oFrm     <= 7'd0;
            oPhrLock <= 1'b0;
            oGrpLock <= 1'b0;
            oFrmLock <= 1'b0;
            oErr     <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_widx   <= w_widx_nx;
            r_good   <= w_good_nx;
            r_miss   <= w_miss_nx;
            r_bad    <= w_bad_nx;
            r_gsr    <= w_gsr_nx;
            oWord    <= w_word_nx;
            oVal     <= w_val_nx;
            oAddr    <= w_addr_nx;
            oGrp     <= w_grp_nx;
            oFrm     <= w_frm_nx;
            oPhrLock <= w_plk_nx;
            oGrpLock <= w_glk_nx;
            oFrmLock <= w_flk_nx;
            oErr     <= w_err_nx;
        end
    end
endmodule

// File: tb/tb_m16_rx.sv
// Directed bench for m16_rx: an M16 transmitter model feeds the line, a scoreboard checks each word.
module tb_m16_rx;
    logic        iClkOrb = 1'b0;
    logic        reset;
    logic        iOrbit;
    logic [11:0] oWord;
    logic        oVal;
    logic [10:0] oAddr;
    logic [4:0]  oGrp;
    logic [6:0]  oFrm;
    logic        oPhrLock, oGrpLock, oFrmLock, oErr;

    m16_rx dut (
        .iClkOrb(iClkOrb), .reset(reset), .iOrbit(iOrbit),
        .oWord(oWord), .oVal(oVal), .oAddr(oAddr), .oGrp(oGrp), .oFrm(oFrm),
        .oPhrLock(oPhrLock), .oGrpLock(oGrpLock), .oFrmLock(oFrmLock), .oErr(oErr)
    );

    always #5 iClkOrb = ~iClkOrb;

    typedef struct {
        logic [11:0] w;
        int a, g, f, c;
    } ent_t;

    ent_t q[$];
    ent_t e;
    int   cyc = 0;
    int   n_tests = 0, n_fail = 0;
    int   n_val = 0, last_val = 0, err_cnt = 0;
    logic chk_en = 1'b0, tx_go = 1'b0, tx_stop = 1'b0, slip_req = 1'b0;

    always @(posedge iClkOrb) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Transmitter-side marker for bit 11 of word a in group g of frame f.
    function automatic logic mark(int a, int g, int f);
        logic [31:0] pm;
        logic [7:0]  gp;
        int k, p;
        pm = 32'h4504_0154;
        k  = a % 32;
        p  = a / 32;
        if (k != 16) return pm[k];
        if (p >= 56) begin
            gp = (g == 31) ? 8'b1000_1101 : 8'b0111_0010;
            return gp[63 - p];
        end
        return (p == 7) && (g == 0) && (f == 0);
    endfunction

    initial begin
        int a, g, f;
        logic [11:0] w;
        iOrbit = 1'b0;
        a = 1696; g = 31; f = 127;
        wait (tx_go);
        while (!tx_stop) begin
            if (slip_req) begin
                repeat (20) @(posedge iClkOrb);
                slip_req = 1'b0;
            end
            w = {mark(a, g, f), 11'(a)};
            for (int b = 11; b >= 0; b--) begin
                @(posedge iClkOrb);
                #1;
                iOrbit = w[b];
                if (b == 0) q.push_back('{w: w, a: a, g: g, f: f, c: cyc});
                repeat (3) @(posedge iClkOrb);
            end
            a++;
            if (a == 2048) begin
                a = 0;
                g = (g + 1) % 32;
                f = (f + 1) % 128;
            end
        end
    end

    // Scoreboard: each emitted word must match the word whose LSB started 5 edges earlier.
    always @(negedge iClkOrb) begin
        while (q.size() > 0 && q[0].c + 5 < cyc) void'(q.pop_front());
        if (reset && oErr) err_cnt++;
        if (reset && oVal && chk_en) begin
            if (q.size() == 0) begin
                chk("val_unexpected", 32'(oVal), 32'd0);
            end else begin
                e = q.pop_front();
                n_val++;
                chk("latency", 32'(cyc - e.c), 32'd5);
                chk("word", 32'(oWord), 32'(e.w));
                chk("err_in_lock", 32'(oErr), 32'd0);
                if (last_val != 0) chk("spacing", 32'(cyc - last_val), 32'd48);
                last_val = cyc;
                if (oGrpLock) begin
                    chk("addr", 32'(oAddr), 32'(e.a));
                    chk("grp", 32'(oGrp), 32'(e.g));
                end
                if (oFrmLock) chk("frm", 32'(oFrm), 32'(e.f));
            end
        end
    end

    initial begin
        #(950_000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d expected below %0d", cyc, 95000);
        $fatal(1);
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_word"}, 32'(oWord), 32'd0);
        chk({tag, "_val"},  32'(oVal), 32'd0);
        chk({tag, "_addr"}, 32'(oAddr), 32'd0);
        chk({tag, "_grp"},  32'(oGrp), 32'd0);
        chk({tag, "_frm"},  32'(oFrm), 32'd0);
        chk({tag, "_locks"}, 32'({oPhrLock, oGrpLock, oFrmLock}), 32'd0);
        chk({tag, "_err"},  32'(oErr), 32'd0);
    endtask

    initial begin
        int t, idle_bad, e0, v0;
        reset = 1'b1;
        #3 reset = 1'b0;
        repeat (3) @(negedge iClkOrb);
        chk_all_zero("rst");
        reset = 1'b1;

        idle_bad = 0;
        repeat (10000) begin
            @(negedge iClkOrb);
            if (oVal || oPhrLock || oGrpLock || oFrmLock || oErr) idle_bad++;
        end
        chk("idle_activity", 32'(idle_bad), 32'd0);

        // Phrase lock: hunt hit at word 1727, confirmed at the end of word 1759.
        tx_go = 1'b1;
        t = 0;
        while (oPhrLock !== 1'b1 && t < 6000) begin @(negedge iClkOrb); t++; end
        chk("plk_rise", 32'(oPhrLock), 32'd1);
        chk("plk_word", 32'(q[q.size()-1].a), 32'd1759);
        chk("plk_noval", 32'(oVal), 32'd0);
        last_val = 0;
        chk_en = 1'b1;

        t = 0;
        while (oGrpLock !== 1'b1 && t < 15000) begin @(negedge iClkOrb); t++; end
        chk("glk_rise", 32'(oGrpLock), 32'd1);
        chk("glk_val", 32'(oVal), 32'd1);
        chk("glk_addr", 32'(oAddr), 32'd2032);
        chk("glk_grp", 32'(oGrp), 32'd31);

        t = 0;
        @(negedge iClkOrb);
        while (!(oVal === 1'b1 && oAddr == 11'd0) && t < 1500) begin @(negedge iClkOrb); t++; end
        chk("wrap_addr", 32'(oAddr), 32'd0);
        chk("wrap_grp", 32'(oGrp), 32'd0);

        t = 0;
        while (oFrmLock !== 1'b1 && t < 13000) begin @(negedge iClkOrb); t++; end
        chk("flk_rise", 32'(oFrmLock), 32'd1);
        chk("flk_addr", 32'(oAddr), 32'd240);
        chk("flk_frm", 32'(oFrm), 32'd0);
        repeat (200) @(negedge iClkOrb);

        // 5-bit slip: marker errors while locked, then back to hunt and relock.
        e0 = err_cnt;
        chk_en = 1'b0;
        slip_req = 1'b1;
        t = 0;
        while (oPhrLock !== 1'b0 && t < 9600) begin @(negedge iClkOrb); t++; end
        chk("slip_unlock", 32'(oPhrLock), 32'd0);
        chk("slip_err_seen", 32'(err_cnt > e0), 32'd1);
        chk("slip_glk", 32'({oGrpLock, oFrmLock}), 32'd0);
        chk("slip_grp", 32'(oGrp), 32'd0);
        t = 0;
        while (oPhrLock !== 1'b1 && t < 7200) begin @(negedge iClkOrb); t++; end
        chk("slip_relock", 32'(oPhrLock), 32'd1);
        last_val = 0;
        v0 = n_val;
        chk_en = 1'b1;
        repeat (1900) @(negedge iClkOrb);
        chk("relock_nval", 32'(n_val - v0), 32'd39);

        // Asynchronous reset while locked.
        reset = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        chk_en = 1'b0;
        repeat (5) @(negedge iClkOrb);
        reset = 1'b1;
        t = 0;
        while (oPhrLock !== 1'b1 && t < 6000) begin @(negedge iClkOrb); t++; end
        chk("rst_relock", 32'(oPhrLock), 32'd1);
        last_val = 0;
        v0 = n_val;
        chk_en = 1'b1;
        repeat (500) @(negedge iClkOrb);
        chk("rst_relock_nval", 32'(n_val - v0), 32'd10);

        tx_stop = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
